job_write_scheduler: RTL and testbench

- Shares one delayed-write output register between NREQ requesters.
- Each requester asks to drive a value, or release it to high-Z, after a per-request cycle delay.
- A round-robin arbiter grants one request at a time, counts the delay, applies the value and signals completion.
- Sits between requester logic and a shared output wire, in place of ad-hoc hierarchical writes to a common register.

---
 rtl/job_write_scheduler.sv | 130 +++++++++++++
 tb/tb_job_write_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/job_write_scheduler.sv
// Round-robin scheduler for one shared delayed-write output register.
// Grants one requester, counts its delay, then applies value or release.
module job_write_scheduler #(
  parameter int NREQ  = 4,
  parameter int DW    = 1,
  parameter int DLY_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DW-1:0]    req_data,
  input  logic [NREQ-1:0]       req_z,
  input  logic [NREQ*DLY_W-1:0] req_dly,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [DW-1:0]         out,
  output logic                  out_oe,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic               z_q, z_d;
  logic [DW-1:0]      out_q, out_d;
  logic               oe_q, oe_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [PW-1:0]      sel;
  int                 si;

  // Rotating search starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    si = int'(sel);
  end

  // Next-state logic; rr_ptr doubles as the owner of the pending write
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    z_d      = z_q;
    out_d    = out_q;
    oe_d     = oe_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[sel] = 1'b1;
          rr_ptr_d   = sel;
          dat_d      = req_data[si*DW +: DW];
          z_d        = req_z[si];
          cnt_d      = req_dly[si*DLY_W +: DLY_W];
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!z_q) out_d = dat_q;
          oe_d             = ~z_q;
          done_d[rr_ptr_q] = 1'b1;
          busy_d           = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= PW'(NREQ - 1);
      cnt_q    <= '0;
      dat_q    <= '0;
      z_q      <= 1'b0;
      out_q    <= '0;
      oe_q     <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      z_q      <= z_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign out    = out_q;
  assign out_oe = oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_job_write_scheduler.sv
// Directed bench for job_write_scheduler.
// Expected values are hand-derived from the grant/apply timing.
module tb_job_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_data;
  logic [3:0]  req_z;
  logic [15:0] req_dly;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [0:0]  out;
  logic        out_oe;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] seen;

  job_write_scheduler #(.NREQ(4), .DW(1), .DLY_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_z(req_z), .req_dly(req_dly), .gnt(gnt), .done(done),
    .out(out), .out_oe(out_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1011; req_data = '0;
    req_z = '0; req_dly = '0;
    step(); step(); step();
    chk("rst_out", 16'(out), 16'h0);
    chk("rst_oe", 16'(out_oe), 16'h0);
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    req = '0; rst_n = 1'b1;
    step(); step();
    chk("idle_gnt", 16'(gnt), 16'h0);
    chk("idle_busy", 16'(busy), 16'h0);

    // requester 0 releases, no delay
    req = 4'b0001; req_z = 4'b0001; req_dly = 16'h0000;
    step();
    chk("t1_gnt", 16'(gnt), 16'h1);
    chk("t1_busy", 16'(busy), 16'h1);
    req = '0;
    step();
    chk("t1_done", 16'(done), 16'h1);
    chk("t1_oe", 16'(out_oe), 16'h0);
    chk("t1_gnt_clr", 16'(gnt), 16'h0);
    chk("t1_busy_clr", 16'(busy), 16'h0);

    // requester 1 drives 1 after one cycle
    req = 4'b0010; req_z = '0; req_data = 4'b0010; req_dly = 16'h0010;
    step();
    chk("t2_gnt", 16'(gnt), 16'h2);
    req = '0;
    step();
    chk("t2_done_early", 16'(done), 16'h0);
    chk("t2_out_early", 16'(out), 16'h0);
    step();
    chk("t2_done", 16'(done), 16'h2);
    chk("t2_out", 16'(out), 16'h1);
    chk("t2_oe", 16'(out_oe), 16'h1);

    // round robin with all requesters held
    do_reset();
    req = 4'b1111; req_z = '0; req_data = 4'b1010; req_dly = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_gnt", 16'(gnt), 16'(1 << (i % 4)));
      chk("rr_busy_hi", 16'(busy), 16'h1);
      step();
      chk("rr_done", 16'(done), 16'(1 << (i % 4)));
      chk("rr_busy_lo", 16'(busy), 16'h0);
      chk("rr_out", 16'(out), 16'((i % 4) & 1));
    end
    req = '0;
    step();

    // maximum delay; data change during WAIT ignored
    req = 4'b0010; req_data = 4'b0010; req_dly = 16'h00F0;
    step();
    chk("md_gnt", 16'(gnt), 16'h2);
    req = '0; req_data = '0; req_dly = '0;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen |= done;
    end
    chk("md_no_early_done", 16'(seen), 16'h0);
    chk("md_out_hold", 16'(out), 16'h0);
    chk("md_busy", 16'(busy), 16'h1);
    step();
    chk("md_done", 16'(done), 16'h2);
    chk("md_out", 16'(out), 16'h1);

    // reset in the middle of a long wait
    step();
    req = 4'b0100; req_data = 4'b0100; req_dly = 16'h0A00;
    step();
    chk("mr_gnt", 16'(gnt), 16'h4);
    req = '0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mr_out", 16'(out), 16'h0);
    chk("mr_oe", 16'(out_oe), 16'h0);
    chk("mr_busy", 16'(busy), 16'h0);
    step();
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen |= done;
    end
    chk("mr_no_done", 16'(seen), 16'h0);

    // withdrawn request never granted, held one waits its turn
    req = 4'b0001; req_data = 4'b0001; req_dly = 16'h0003;
    step();
    chk("wb_gnt0", 16'(gnt), 16'h1);
    seen = '0;
    req = 4'b1100;
    step();
    seen |= gnt;
    req = 4'b1000;
    step(); seen |= gnt;
    step(); seen |= gnt;
    step();
    seen |= gnt;
    chk("wb_done0", 16'(done), 16'h1);
    chk("wb_no_gnt_wait", 16'(seen), 16'h0);
    step();
    chk("wb_gnt3", 16'(gnt), 16'h8);
    req = '0;
    step();
    chk("wb_done3", 16'(done), 16'h8);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= gnt;
    end
    chk("wb_no_gnt2", 16'(seen), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
